// File: rtl/adder_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adder_share_arbiter
//  Description : Round-robin arbiter that time-shares one external
//                combinational W-bit adder between N_REQ requesters.
//                Each accepted request goes through three phases:
//                  IDLE (accept) -> EVAL (adder evaluates) -> RESP (return).
//                The result is returned on one response channel, tagged
//                with the index of the requester that owns it.
//
//  Ports:
//    clk        in   1          rising-edge clock
//    rst_n      in   1          asynchronous active-low reset
//    req_valid  in   N_REQ      per-requester request valid
//    req_a      in   N_REQ*W    operand A, requester i at [i*W +: W]
//    req_b      in   N_REQ*W    operand B, same packing
//    req_ready  out  N_REQ      one-hot accept pulse (IDLE only)
//    add_in     out  2*W        adder operands, add_in[2k]=a[k], [2k+1]=b[k]
//    add_out    in   W+1        adder result {carry, sum}
//    rsp_valid  out  1          response valid
//    rsp_ready  in   1          response consumer ready
//    rsp_id     out  IDW        requester index that owns the response
//    rsp_sum    out  W+1        {carry, sum}
//    busy       out  1          high whenever not in IDLE
//    ops_done   out  16         completed responses, saturating
//
//  Revision    : 1.0  initial release
// ============================================================================
module adder_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 12,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic [2*W-1:0]     add_in,
    input  logic [W:0]         add_out,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [W:0]         rsp_sum,
    output logic               busy,
    output logic [15:0]        ops_done
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_eval = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    localparam logic [IDW-1:0] c_last_idx = IDW'(N_REQ - 1);
    localparam logic [15:0]    c_ops_max  = 16'hFFFF;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [W-1:0]     r_op_a;
    logic [W-1:0]     r_op_b;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_rr_ptr;
    logic [W:0]       r_rsp_sum;
    logic [IDW-1:0]   r_rsp_id;
    logic [15:0]      r_ops_done;

    logic             w_hi_found;
    logic [IDW-1:0]   w_hi_idx;
    logic             w_any_valid;
    logic [IDW-1:0]   w_lo_idx;
    logic [IDW-1:0]   w_gnt_idx;
    logic             w_accept;
    logic             w_rsp_fire;

    // ------------------------------------------------------------------------
    // Round-robin search. Scanning downward means the last hit is the lowest
    // index, so w_hi_idx is the lowest valid index >= r_rr_ptr and w_lo_idx
    // is the lowest valid index overall (used when the search must wrap).
    // ------------------------------------------------------------------------
    always_comb begin
        w_hi_found  = 1'b0;
        w_hi_idx    = '0;
        w_any_valid = 1'b0;
        w_lo_idx    = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                w_any_valid = 1'b1;
                w_lo_idx    = IDW'(j);
                if (IDW'(j) >= r_rr_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IDW'(j);
                end
            end
        end
        w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    // ------------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rsp_fire  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_any_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_st_eval;
                end
            end
            c_st_eval: begin
                w_state_nxt = c_st_resp;
            end
            c_st_resp: begin
                if (rsp_ready) begin
                    w_rsp_fire  = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_id       <= '0;
            r_rr_ptr   <= '0;
            r_rsp_sum  <= '0;
            r_rsp_id   <= '0;
            r_ops_done <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op_a   <= req_a[w_gnt_idx*W +: W];
                r_op_b   <= req_b[w_gnt_idx*W +: W];
                r_id     <= w_gnt_idx;
                r_rr_ptr <= (w_gnt_idx == c_last_idx) ? '0 : w_gnt_idx + IDW'(1);
            end
            // add_in has been stable from r_op_a/r_op_b for the whole EVAL
            // cycle, so the adder output is settled at this edge.
            if (r_state == c_st_eval) begin
                r_rsp_sum <= add_out;
                r_rsp_id  <= r_id;
            end
            if (w_rsp_fire && (r_ops_done != c_ops_max)) begin
                r_ops_done <= r_ops_done + 16'd1;
            end
        end
    end

    // Interleaved operand bus; holds the last operands outside EVAL.
    for (genvar k = 0; k < W; k++) begin : g_interleave
        assign add_in[2*k]   = r_op_a[k];
        assign add_in[2*k+1] = r_op_b[k];
    end

    assign rsp_valid = (r_state == c_st_resp);
    assign busy      = (r_state != c_st_idle);
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign ops_done  = r_ops_done;

endmodule
`default_nettype wire
